// File: rtl/pila_retorno.sv
// rtl/pila_retorno.sv - hardware return-address stack with saturating pointer
// Optional sticky ovf/udf flags when PILA_ERR_FLAGS_EN is defined.
module pila_retorno #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [PW:0]   count,
  output logic          ovf,
  output logic          udf
);

  logic [PW:0]   sp;
  logic [AW-1:0] mem [0:DEPTH-1];
  logic [PW-1:0] sp_lo;
  logic [PW-1:0] top_idx;
  logic          do_replace;
  logic          do_push;
  logic          do_pop;
  logic          ovf_evt;
  logic          udf_evt;

  assign empty = (sp == '0);
  assign full  = (sp == (PW+1)'(DEPTH));
  assign count = sp;

  // At sp==DEPTH the low bits are zero, so subtracting one lands on DEPTH-1.
  assign sp_lo   = sp[PW-1:0];
  assign top_idx = sp_lo - PW'(1);

  assign dout = empty ? '0 : mem[top_idx];

  always_comb begin
    do_replace = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_evt    = 1'b0;
    udf_evt    = 1'b0;
    if (push && pop && !empty) begin
      do_replace = 1'b1;
    end else if (push) begin
      // push alone, or push+pop on an empty stack, both act as a plain push
      if (full) ovf_evt = 1'b1;
      else      do_push = 1'b1;
    end else if (pop) begin
      if (empty) udf_evt = 1'b1;
      else       do_pop  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + (PW+1)'(1);
    end else if (do_pop) begin
      sp <= sp - (PW+1)'(1);
    end
  end

  // Storage is deliberately not reset; empty gating keeps it off dout.
  always_ff @(posedge clk) begin
    if (do_push)    mem[sp_lo]   <= din;
    if (do_replace) mem[top_idx] <= din;
  end

`ifdef PILA_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_evt) ovf <= 1'b1;
      if (udf_evt) udf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
